// File: rtl/lc4_regfile_ss.sv
// Dual-issue register file for a superscalar LC4 core.
// Two write ports (A = older, B = younger instruction) and four
// combinational read ports with same-cycle write-to-read bypass.
// Port B takes priority whenever both ports target one register.
module lc4_regfile_ss #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gwe,
  input  logic [AW-1:0]    i_rs_A,
  input  logic [AW-1:0]    i_rt_A,
  input  logic [AW-1:0]    i_rs_B,
  input  logic [AW-1:0]    i_rt_B,
  output logic [WIDTH-1:0] o_rs_data_A,
  output logic [WIDTH-1:0] o_rt_data_A,
  output logic [WIDTH-1:0] o_rs_data_B,
  output logic [WIDTH-1:0] o_rt_data_B,
  input  logic [AW-1:0]    i_rd_A,
  input  logic [AW-1:0]    i_rd_B,
  input  logic [WIDTH-1:0] i_wdata_A,
  input  logic [WIDTH-1:0] i_wdata_B,
  input  logic             i_rd_we_A,
  input  logic             i_rd_we_B
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             eff_a;
  logic             eff_b;

  // A write only happens outside reset and while the pipeline is not stalled.
  assign eff_a = rst & gwe & i_rd_we_A;
  assign eff_b = rst & gwe & i_rd_we_B;

  // Bypass selection for one read port: B's write is younger so it is
  // checked first; reset forces zero so no stale value leaks out.
  function automatic logic [WIDTH-1:0] rd_mux(
    input logic             rst_ok,
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] stored,
    input logic             wa,
    input logic [AW-1:0]    rda,
    input logic [WIDTH-1:0] wda,
    input logic             wb,
    input logic [AW-1:0]    rdb,
    input logic [WIDTH-1:0] wdb
  );
    logic [WIDTH-1:0] res;
    res = stored;
    if (!rst_ok)
      res = '0;
    else if (wb && (rdb == addr))
      res = wdb;
    else if (wa && (rda == addr))
      res = wda;
    return res;
  endfunction

  // Storage: async clear; B's assignment is last so it wins on a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs <= '{default: '0};
    end else begin
      if (eff_a) regs[i_rd_A] <= i_wdata_A;
      if (eff_b) regs[i_rd_B] <= i_wdata_B;
    end
  end

  // Four independent combinational read ports with same-cycle bypass.
  always_comb begin
    o_rs_data_A = rd_mux(rst, i_rs_A, regs[i_rs_A], eff_a, i_rd_A, i_wdata_A,
                         eff_b, i_rd_B, i_wdata_B);
    o_rt_data_A = rd_mux(rst, i_rt_A, regs[i_rt_A], eff_a, i_rd_A, i_wdata_A,
                         eff_b, i_rd_B, i_wdata_B);
    o_rs_data_B = rd_mux(rst, i_rs_B, regs[i_rs_B], eff_a, i_rd_A, i_wdata_A,
                         eff_b, i_rd_B, i_wdata_B);
    o_rt_data_B = rd_mux(rst, i_rt_B, regs[i_rt_B], eff_a, i_rd_A, i_wdata_A,
                         eff_b, i_rd_B, i_wdata_B);
  end

endmodule

// File: tb/tb_lc4_regfile_ss.sv
// Bench for lc4_regfile_ss: default 16x8 instance driven through a
// reference model and scoreboard, plus a 32x32 instance for the wide case.
module tb_lc4_regfile_ss;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic [2:0]  rs_a, rt_a, rs_b, rt_b, rd_a, rd_b;
  logic [15:0] wd_a, wd_b;
  logic        we_a, we_b;
  logic [15:0] q_rs_a, q_rt_a, q_rs_b, q_rt_b;

  logic [4:0]  w_rs_a, w_rt_a, w_rs_b, w_rt_b, w_rd_a, w_rd_b;
  logic [31:0] w_wd_a, w_wd_b;
  logic        w_we_a, w_we_b;
  logic [31:0] w_q_rs_a, w_q_rt_a, w_q_rs_b, w_q_rt_b;

  int vectors = 0;
  int errors  = 0;

  logic [15:0] mdl [8];

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sbq[$];

  always #5 clk = ~clk;

  lc4_regfile_ss dut (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rs_A(rs_a), .i_rt_A(rt_a), .i_rs_B(rs_b), .i_rt_B(rt_b),
    .o_rs_data_A(q_rs_a), .o_rt_data_A(q_rt_a),
    .o_rs_data_B(q_rs_b), .o_rt_data_B(q_rt_b),
    .i_rd_A(rd_a), .i_rd_B(rd_b), .i_wdata_A(wd_a), .i_wdata_B(wd_b),
    .i_rd_we_A(we_a), .i_rd_we_B(we_b)
  );

  lc4_regfile_ss #(.WIDTH(32), .NREGS(32)) dut_w (
    .clk(clk), .rst(rst), .gwe(gwe),
    .i_rs_A(w_rs_a), .i_rt_A(w_rt_a), .i_rs_B(w_rs_b), .i_rt_B(w_rt_b),
    .o_rs_data_A(w_q_rs_a), .o_rt_data_A(w_q_rt_a),
    .o_rs_data_B(w_q_rs_b), .o_rt_data_B(w_q_rt_b),
    .i_rd_A(w_rd_a), .i_rd_B(w_rd_b), .i_wdata_A(w_wd_a), .i_wdata_B(w_wd_b),
    .i_rd_we_A(w_we_a), .i_rd_we_B(w_we_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Expected read value from the model, including bypass rules.
  function automatic logic [15:0] mread(input logic [2:0] a);
    logic [15:0] r;
    r = mdl[a];
    if (!rst)                               r = 16'h0000;
    else if (gwe && we_b && (rd_b == a))    r = wd_b;
    else if (gwe && we_a && (rd_a == a))    r = wd_a;
    return r;
  endfunction

  task automatic drive(input logic [2:0] ra, input logic [2:0] ta,
                       input logic [2:0] rb, input logic [2:0] tb,
                       input logic g,
                       input logic wa, input logic [2:0] da, input logic [15:0] va,
                       input logic wb, input logic [2:0] db, input logic [15:0] vb);
    rs_a = ra; rt_a = ta; rs_b = rb; rt_b = tb; gwe = g;
    we_a = wa; rd_a = da; wd_a = va;
    we_b = wb; rd_b = db; wd_b = vb;
  endtask

  // Push the model's prediction for all four ports, let logic settle, compare.
  task automatic sample();
    sbq.push_back('{"rs_A", {16'h0, mread(rs_a)}});
    sbq.push_back('{"rt_A", {16'h0, mread(rt_a)}});
    sbq.push_back('{"rs_B", {16'h0, mread(rs_b)}});
    sbq.push_back('{"rt_B", {16'h0, mread(rt_b)}});
    #1;
    begin
      exp_t e;
      e = sbq.pop_front(); chk(e.tag, {16'h0, q_rs_a}, e.exp);
      e = sbq.pop_front(); chk(e.tag, {16'h0, q_rt_a}, e.exp);
      e = sbq.pop_front(); chk(e.tag, {16'h0, q_rs_b}, e.exp);
      e = sbq.pop_front(); chk(e.tag, {16'h0, q_rt_b}, e.exp);
    end
  endtask

  // Advance one clock and retire the effective writes into the model.
  task automatic edge_step();
    @(posedge clk);
    if (rst && gwe) begin
      if (we_a) mdl[rd_a] = wd_a;
      if (we_b) mdl[rd_b] = wd_b;
    end
    @(negedge clk);
  endtask

  task automatic cycle();
    sample();
    edge_step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    drive(0, 1, 2, 3, 1'b1, 1'b1, 3'd3, 16'h5555, 1'b1, 3'd2, 16'h6666);
    w_rs_a = 0; w_rt_a = 0; w_rs_b = 0; w_rt_b = 0;
    w_rd_a = 0; w_rd_b = 0; w_wd_a = 0; w_wd_b = 0; w_we_a = 0; w_we_b = 0;

    // Reset state: outputs zero and writes/bypass suppressed.
    @(negedge clk);
    cycle();
    chk("rst_r3", {16'h0, q_rs_a}, 32'h0);
    #2 rst = 1'b1;

    // Write r3=0x1234, read it back, then pulse reset mid-cycle.
    drive(3, 3, 3, 3, 1'b1, 1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0);
    cycle();
    drive(3, 3, 3, 3, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    sample();
    chk("r3_before_rst", {16'h0, q_rs_a}, 32'h1234);
    #2 rst = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0;
    #1;
    chk("rst_async_rs_A", {16'h0, q_rs_a}, 32'h0);
    chk("rst_async_rt_B", {16'h0, q_rt_b}, 32'h0);
    edge_step();
    #2 rst = 1'b1;
    #1;
    chk("r3_after_rst", {16'h0, q_rs_a}, 32'h0);
    @(negedge clk);
    cycle();

    // Basic write then read on two ports.
    drive(0, 0, 0, 0, 1'b1, 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 16'h0);
    cycle();
    drive(5, 0, 0, 5, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    sample();
    chk("r5_rs_A", {16'h0, q_rs_a}, 32'hBEEF);
    chk("r5_rt_B", {16'h0, q_rt_b}, 32'hBEEF);
    edge_step();

    // Same-cycle bypass from A.
    drive(0, 0, 2, 0, 1'b1, 1'b1, 3'd2, 16'h00AA, 1'b0, 3'd0, 16'h0);
    sample();
    chk("byp_r2", {16'h0, q_rs_b}, 32'h00AA);
    edge_step();
    drive(2, 2, 2, 2, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    cycle();

    // Collision: B is younger and wins both bypass and storage.
    drive(7, 7, 7, 7, 1'b1, 1'b1, 3'd7, 16'h1111, 1'b1, 3'd7, 16'h2222);
    sample();
    chk("conf_byp", {16'h0, q_rs_a}, 32'h2222);
    edge_step();
    drive(7, 7, 7, 7, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    sample();
    chk("conf_store", {16'h0, q_rt_b}, 32'h2222);
    edge_step();

    // Stall: gwe=0 freezes storage and disables bypass.
    drive(1, 1, 1, 1, 1'b1, 1'b1, 3'd1, 16'h0042, 1'b0, 3'd0, 16'h0);
    cycle();
    drive(1, 1, 1, 1, 1'b0, 1'b1, 3'd1, 16'hFFFF, 1'b1, 3'd1, 16'hEEEE);
    sample();
    chk("stall_during", {16'h0, q_rs_a}, 32'h0042);
    edge_step();
    drive(1, 1, 1, 1, 1'b1, 1'b0, 3'd1, 16'hFFFF, 1'b0, 3'd1, 16'hEEEE);
    sample();
    chk("stall_after", {16'h0, q_rs_b}, 32'h0042);
    edge_step();

    // Two different addresses written on one edge.
    drive(4, 6, 4, 6, 1'b1, 1'b1, 3'd4, 16'hAAAA, 1'b1, 3'd6, 16'hBBBB);
    cycle();
    drive(4, 6, 6, 4, 1'b1, 1'b0, 3'd4, 16'h9999, 1'b0, 3'd6, 16'h8888);
    sample();
    chk("dual_r4", {16'h0, q_rs_a}, 32'hAAAA);
    chk("dual_r6", {16'h0, q_rt_a}, 32'hBBBB);
    edge_step();

    // Randomised traffic against the model.
    for (int n = 0; n < 60; n++) begin
      drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
      cycle();
    end
    drive(0, 0, 0, 0, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);

    // Wide instance: B writes r31, r0 stays zero.
    w_rs_a = 5'd31; w_rt_a = 5'd31; w_rs_b = 5'd31; w_rt_b = 5'd31;
    w_we_b = 1'b1; w_rd_b = 5'd31; w_wd_b = 32'hDEADBEEF;
    #1;
    chk("w_byp_rs_A", w_q_rs_a, 32'hDEADBEEF);
    edge_step();
    w_we_b = 1'b0; w_wd_b = 32'h0;
    #1;
    chk("w_rs_A", w_q_rs_a, 32'hDEADBEEF);
    chk("w_rt_A", w_q_rt_a, 32'hDEADBEEF);
    chk("w_rs_B", w_q_rs_b, 32'hDEADBEEF);
    chk("w_rt_B", w_q_rt_b, 32'hDEADBEEF);
    w_rs_a = 5'd0;
    #1;
    chk("w_r0", w_q_rs_a, 32'h0);

    if (sbq.size() != 0) chk("sbq_empty", 32'(sbq.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/lc4_regfile_ss.md
LC4_REGFILE_SS -- requirements
Module: lc4_regfile_ss

Interface
REQ-001 Parameter WIDTH, default 16: data bits per register.
REQ-002 Parameter NREGS, default 8: register count, power of two, minimum 2.
REQ-003 Parameter AW, default $clog2(NREGS): register-address width.
REQ-004 The block SHALL be clocked by one clock; reset is asynchronous and active-low (ports clk and rst below).
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-low reset: 0 = reset asserted.
REQ-007 gwe  input  1  global write enable; 0 freezes all state.
REQ-008 i_rs_A, i_rt_A, i_rs_B, i_rt_B  input  AW each  read addresses, pipe A and pipe B.
REQ-009 o_rs_data_A, o_rt_data_A, o_rs_data_B, o_rt_data_B  output  WIDTH each  read data.
REQ-010 i_rd_A, i_rd_B  input  AW each  write addresses.
REQ-011 i_wdata_A, i_wdata_B  input  WIDTH each  write data.
REQ-012 i_rd_we_A, i_rd_we_B  input  1 each  per-port write enables.

Function
REQ-013 Storage SHALL be NREGS registers of WIDTH bits; all four read ports are combinational and independent.
REQ-014 Effective write on port X (X = A or B) SHALL be: rst=1 AND gwe=1 AND i_rd_we_X=1.
REQ-015 An effective write SHALL update register i_rd_X on the rising edge of clk; latency 1 cycle to storage.
REQ-016 Same-cycle bypass: a read address matching an effective write address SHALL return that port's i_wdata in the same cycle, not the stored value.
REQ-017 Port B is the younger instruction: if both ports effectively write the same address, B's data SHALL be stored and B's data SHALL be bypassed.
REQ-018 If only A writes address n, a read of n SHALL return i_wdata_A.
REQ-019 If both ports write different addresses, both registers SHALL update on the same edge.
REQ-020 With gwe=0, no register SHALL change and bypass SHALL be disabled: reads return stored values.
REQ-021 With i_rd_we_X=0, i_rd_X and i_wdata_X SHALL have no effect.
REQ-022 All addresses are full-range: no out-of-range case exists because NREGS = 2^AW.
REQ-023 No register is hardwired to zero; every address is writable.
REQ-024 Read data SHALL depend only on the current address inputs, storage and the current write inputs; no read latency, no X propagation from unselected registers.

Reset
REQ-025 rst=0 SHALL clear every register to 0 immediately, independent of clk.
REQ-026 While rst=0, all four outputs SHALL read 0, and writes and bypass SHALL be suppressed.
REQ-027 After rst deasserts, the first write SHALL take effect at the first rising edge on which the REQ-014 conditions hold.
REQ-028 Deassertion of reset between edges SHALL NOT corrupt any register.

Verification
REQ-029 Reset: pulse rst=0 mid-cycle after writing 0x1234 to r3 -> all outputs read 0000 immediately; r3 reads 0000 after release.
REQ-030 Basic write/read: A writes r5=0xBEEF (we=1, gwe=1); next cycle rs_A=5, rt_B=5 -> both outputs read BEEF.
REQ-031 Bypass: same cycle A writes r2=0x00AA and rs_B=2 -> o_rs_data_B=00AA before the edge; r2=00AA after the edge.
REQ-032 Write conflict: A writes r7=0x1111 and B writes r7=0x2222 in the same cycle -> bypass gives 2222; after the edge r7 reads 2222.
REQ-033 Stall: gwe=0, A we=1 writes r1=0xFFFF, r1 previously 0x0042 -> r1 reads 0042 both during and after the edge; reads do not bypass.
REQ-034 Parameter sweep: WIDTH=32, NREGS=32 -> write 0xDEADBEEF to r31 via B and read it back on all four ports; r0 remains 0.
